dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target answering the core's load/store requests: the responder end of the core's data-memory interface.
- Adds a valid/ready request handshake, a configurable wait-state count, RV32I byte/half/word sizing via funct3, load sign/zero-extension, and an error response for misaligned or out-of-range accesses.
- Sits between the core's memory stage and the word-organised storage array it owns.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; legal word index range is 0..DEPTH-1.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access faulted; valid only with rsp_valid.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; count = 0; captured request fields cleared.
  - Outputs: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Array contents are not reset.
- Single outstanding request only. FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready at edge N: capture we/addr/wdata/funct3, load count = LATENCY-1, go to WAIT.
  - req_valid without acceptance has no effect.
- WAIT:
  - req_ready = 0.
  - While count != 0, decrement count.
  - When count == 0 at an edge, perform the access and go to RESP.
  - The access is performed at edge N+LATENCY.
- RESP:
  - rsp_valid = 1 for exactly one cycle (cycle following edge N+LATENCY); req_ready = 0.
  - Next edge returns to IDLE.
  - There is no response backpressure: the initiator must consume the strobe.
- Back-to-back throughput: one request per LATENCY+2 cycles.
- Fault checks, evaluated on the captured request:
  - Illegal funct3: 011, 110 or 111.
  - Misaligned halfword: H/HU/SH with addr[0] = 1.
  - Misaligned word: W/SW with addr[1:0] != 0.
  - Out of range: addr[31:2] >= DEPTH.
  - Any fault gives rsp_err = 1 and rsp_rdata = 0, and the array is not modified.
- Stores:
  - Read-modify-write of word addr[31:2], replacing only the addressed lanes.
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into lanes {addr[1],0}+1 : {addr[1],0}.
  - SW writes all four lanes.
  - Response: rsp_rdata = 0, rsp_err = 0.
- Loads:
  - Select the addressed lane(s), then extend.
  - B and H sign-extend from bit 7 / bit 15.
  - BU and HU zero-extend.
  - W returns the word unchanged.
- A load immediately following a store to the same word returns the updated data.
- Reset asserted in WAIT or RESP:
  - The request is aborted; no response is issued.
  - A store whose access edge has not yet occurred is not committed; an already committed store remains.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum {IDLE, WAIT, RESP}.
  - LATENCY width constant (4 bits).
- Sub-module dmem_load_align:
  - Combinational lane select plus sign/zero extension.
  - Inputs: word, addr[1:0], funct3. Output: 32-bit result.
  - Reused by future cache/bus logic.
- Store lane merge stays inline.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0; rsp_valid exactly LATENCY cycles after each accept edge; req_ready = 0 while busy.
- After the above, SB 0x11 data 0x7F, LB 0x11 -> 0x0000007F; LW 0x10 -> 0xDEAD7FEF; LBU 0x13 -> 0x000000DE; LB 0x13 -> 0xFFFFFFDE.
- SH 0x22 data 0x8001, then LH 0x22 -> 0xFFFF8001 and LHU 0x22 -> 0x00008001; LW 0x20 upper half = 0x8001, lower half unchanged.
- Faults: LW 0x11 -> err = 1, rdata = 0; SH 0x23 -> err = 1 and a following LW 0x20 is unchanged; funct3 = 011 -> err = 1; LW at DEPTH*4 -> err = 1.
- LATENCY = 4: accept at edge N, rsp_valid high only in cycle N+4..N+5; req_valid held during busy is not accepted until IDLE, then served once.
- Assert reset while in WAIT during an SW to 0x40 (LATENCY = 4) -> no rsp_valid; after release LW 0x40 returns the old contents; req_ready = 1 asynchronously on reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Provides funct3 size codes, FSM state type and latency width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select plus sign/zero extension for RV32I loads.
// Ports: word (raw 32-bit word), addr_lo (byte offset), funct3, result.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    unique case (addr_lo)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
  end

  assign h = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:  result = {{24{b[7]}}, b};
      F3_H:  result = {{16{h[15]}}, h};
      F3_W:  result = word;
      F3_BU: result = {24'd0, b};
      F3_HU: result = {16'd0, h};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: valid/ready request, wait states, sized RMW stores.
// Ports: clk, reset, req_* (request), rsp_valid/rsp_rdata/rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state;
  logic [LAT_W-1:0]   count;
  logic               q_we;
  logic [31:0]        q_addr;
  logic [31:0]        q_wdata;
  logic [2:0]         q_f3;

  logic [31:0]        mem [DEPTH];

  logic               fault;
  logic               access;
  logic [IW-1:0]      idx;
  logic [31:0]        cur_word;
  logic [31:0]        ld_data;
  logic [3:0]         be;
  logic [31:0]        wd_lanes;
  logic [31:0]        merged;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign access    = (state == WAIT) && (count == '0);

  always_comb begin
    logic bad_f3, mis_h, mis_w, oor;
    bad_f3 = (q_f3 == 3'b011) || (q_f3 == 3'b110)
          || (q_f3 == 3'b111);
    mis_h  = ((q_f3 == F3_H) || (q_f3 == F3_HU)) && q_addr[0];
    mis_w  = (q_f3 == F3_W) && (q_addr[1:0] != 2'd0);
    oor    = {2'b00, q_addr[31:2]} >= 32'(DEPTH);
    fault  = bad_f3 || mis_h || mis_w || oor;
  end

  assign idx      = q_addr[IW+1:2];
  assign cur_word = mem[idx];

  dmem_load_align u_align (
    .word    (cur_word),
    .addr_lo (q_addr[1:0]),
    .funct3  (q_f3),
    .result  (ld_data)
  );

  // Byte enables and lane-replicated data for the store merge.
  always_comb begin
    be       = 4'b1111;
    wd_lanes = q_wdata;
    unique case (1'b1)
      (q_f3[1:0] == 2'b00): begin
        be       = 4'b0001 << q_addr[1:0];
        wd_lanes = {4{q_wdata[7:0]}};
      end
      (q_f3[1:0] == 2'b01): begin
        be       = q_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{q_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = q_wdata;
      end
    endcase
  end

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd_lanes[8*i +: 8];
    end
  end

  // Reset forces state to IDLE asynchronously, so an aborted store
  // never reaches an access edge.
  always_ff @(posedge clk) begin
    if (access && q_we && !fault) mem[idx] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      q_we      <= 1'b0;
      q_addr    <= '0;
      q_wdata   <= '0;
      q_f3      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            q_we    <= req_we;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
            q_f3    <= req_funct3;
            count   <= LAT_W'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count != '0) begin
            count <= count - LAT_W'(1);
          end else begin
            rsp_err   <= fault;
            rsp_rdata <= (fault || q_we) ? '0 : ld_data;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte model.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] bm [DEPTH*4];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_acc = -100;
  bit         chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: access of n bytes at addr, little-endian lanes.
  function automatic void model(
    input  bit          we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  f3,
    output logic [31:0] rd,
    output logic        err
  );
    int     n;
    longint v;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
       || (addr % n != 0) || (addr / 4 >= DEPTH);
    rd  = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) bm[addr+i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v | (longint'(bm[addr+i]) << (8*i));
      if (!f3[2] && n < 4 && v[8*n-1])
        v = v - (longint'(1) << (8*n));
      rd = v[31:0];
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("req_ready", {31'd0, req_ready},
            (cyc >= last_acc && cyc <= last_acc + LAT) ? 0 : 1);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 (cyc %0d)",
                   cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rsp_rdata", rsp_rdata, e.rd);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rsp_cycle", cyc, e.due);
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
        total++;
        bad++;
        $display("FAIL missing_rsp: got rsp_valid=0 want 1 (cyc %0d)",
                 cyc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic do_req(bit we, logic [31:0] addr,
                        logic [31:0] wdata, logic [2:0] f3,
                        bit abort = 1'b0);
    int   n;
    exp_t e;
    @(negedge clk);
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 want 1");
      return;
    end
    last_acc = cyc + 1;
    if (!abort) begin
      model(we, addr, wdata, f3, e.rd, e.err);
      e.due = cyc + 1 + LAT;
      sbq.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 4*LAT + 10) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;

    for (int w = 0; w < DEPTH; w++)
      do_req(1'b1, 32'(w*4), $urandom, F3_W);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, F3_W);
    do_req(1'b0, 32'h10, 32'h0, F3_W);
    do_req(1'b1, 32'h11, 32'h7F, F3_B);
    do_req(1'b0, 32'h11, 32'h0, F3_B);
    do_req(1'b0, 32'h10, 32'h0, F3_W);
    do_req(1'b0, 32'h13, 32'h0, F3_BU);
    do_req(1'b0, 32'h13, 32'h0, F3_B);
    do_req(1'b1, 32'h22, 32'h8001, F3_H);
    do_req(1'b0, 32'h22, 32'h0, F3_H);
    do_req(1'b0, 32'h22, 32'h0, F3_HU);
    do_req(1'b0, 32'h20, 32'h0, F3_W);
    do_req(1'b0, 32'h11, 32'h0, F3_W);
    do_req(1'b1, 32'h23, 32'h1234, F3_H);
    do_req(1'b0, 32'h20, 32'h0, F3_W);
    do_req(1'b0, 32'h20, 32'h0, 3'b011);
    do_req(1'b0, 32'(DEPTH*4), 32'h0, F3_W);
    go_idle();
    drain();

    do_req(1'b1, 32'h40, 32'hCAFEF00D, F3_W, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    last_acc  = -100;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    do_req(1'b0, 32'h40, 32'h0, F3_W);
    go_idle();
    drain();

    for (int k = 0; k < 250; k++) begin
      a = 32'($urandom_range(0, DEPTH*4 + 15));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      f = 3'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), a, $urandom, f);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
